// File: rtl/cmp_sched_pkg.sv
// Shared definitions for the round-robin comparator scheduler.
//   CMP_W   : operand width of the shared comparator_4bit
//   state_e : scheduler FSM state encoding
package cmp_sched_pkg;

    localparam int unsigned CMP_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/comparator_4bit.sv
// Combinational 4-bit magnitude comparator.
//   a3..a0 : operand A bits (a3 = MSB)
//   b3..b0 : operand B bits (b3 = MSB)
//   ceq    : A == B
//   clt    : A <  B
//   cgt    : A >  B
module comparator_4bit (
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic ceq,
    output logic clt,
    output logic cgt
);

    logic [3:0] a;
    logic [3:0] b;

    assign a   = {a3, a2, a1, a0};
    assign b   = {b3, b2, b1, b0};
    assign ceq = (a == b);
    assign clt = (a < b);
    assign cgt = (a > b);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_valid : per-requester valid
//   rr_ptr    : index searched first
//   grant     : first valid index at or after rr_ptr (modulo N_REQ)
//   any_valid : at least one requester is valid
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        // Walk from the farthest offset back to rr_ptr so the closest valid wins.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % int'(N_REQ);
            if (req_valid[idx]) begin
                grant     = idx[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Shares one comparator_4bit among N_REQ requesters via round-robin arbitration.
//   clk, rst             : clock (rising edge), async active-high reset
//   req_valid/req_ready  : per-requester handshake; req_ready is one-hot
//   req_a, req_b         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : requester that produced the response
//   rsp_eq/rsp_lt/rsp_gt : registered comparison result
module cmp_rr_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned W     = CMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_eq,
    output logic               rsp_lt,
    output logic               rsp_gt,
    input  logic               rsp_ready
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_eq_q, rsp_eq_d;
    logic            rsp_lt_q, rsp_lt_d;
    logic            rsp_gt_q, rsp_gt_d;

    logic [ID_W-1:0] grant;
    logic            any_valid;
    logic            accept;
    logic            ceq, clt, cgt;

    rr_pick #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .any_valid(any_valid)
    );

    comparator_4bit u_cmp (
        .a3 (op_a_q[3]),
        .a2 (op_a_q[2]),
        .a1 (op_a_q[1]),
        .a0 (op_a_q[0]),
        .b3 (op_b_q[3]),
        .b2 (op_b_q[2]),
        .b1 (op_b_q[1]),
        .b0 (op_b_q[0]),
        .ceq(ceq),
        .clt(clt),
        .cgt(cgt)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_id_d    = gnt_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_gt_d    = rsp_gt_q;
        req_ready   = '0;

        // A held response that is consumed this cycle frees the comparator slot.
        accept = any_valid &&
                 ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));

        if (accept) begin
            req_ready[grant] = 1'b1;
            op_a_d           = req_a[int'(grant)*W +: W];
            op_b_d           = req_b[int'(grant)*W +: W];
            gnt_id_d         = grant;
            rr_ptr_d         = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StCmp;
            end
            StCmp: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_id_d    = gnt_id_q;
                rsp_eq_d    = ceq;
                rsp_lt_d    = clt;
                rsp_gt_d    = cgt;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? StCmp : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_gt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_id_q    <= gnt_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_gt_q    <= rsp_gt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_gt    = rsp_gt_q;

endmodule
